// File: rtl/instruction_loader_if.sv
`timescale 1ns/1ps
// Byte-stream input and instruction-memory write port of the program loader.
interface instruction_loader_if #(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 6
);
  logic [7:0]            i_rx_data;
  logic                  i_rx_valid;
  logic                  o_inst_write_enable;
  logic [ADDR_WIDTH-1:0] o_write_addr;
  logic [SIZE-1:0]       o_write_data;
  logic                  o_loading;
  logic                  o_done;
  logic                  o_error;

  modport slave (
    input  i_rx_data, i_rx_valid,
    output o_inst_write_enable, o_write_addr, o_write_data, o_loading, o_done, o_error
  );

  modport master (
    output i_rx_data, i_rx_valid,
    input  o_inst_write_enable, o_write_addr, o_write_data, o_loading, o_done, o_error
  );
endinterface

// File: rtl/instruction_loader.sv
`timescale 1ns/1ps
// Parses "CMD_LOAD, N, 4*N bytes" from the receiver and writes big-endian words to
// instruction memory from address 0; no backpressure, one byte per cycle, all outputs registered.
module instruction_loader #(
  parameter int         SIZE            = 32,
  parameter int         MAX_INSTRUCTION = 64,
  parameter logic [7:0] CMD_LOAD        = 8'h01
) (
  input  logic                i_clk,
  input  logic                i_rst,
  instruction_loader_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(MAX_INSTRUCTION);
  localparam logic [ADDR_WIDTH:0]   WORD_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {IDLE, COUNT, BYTES, DONE} state_t;

  state_t                r_state,   w_state_nxt;
  logic [SIZE-9:0]       r_sr,      w_sr_nxt;
  logic [1:0]            r_bcnt,    w_bcnt_nxt;
  logic [ADDR_WIDTH-1:0] r_addr,    w_addr_nxt;
  logic [ADDR_WIDTH:0]   r_words,   w_words_nxt;
  logic                  r_we,      w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_waddr,   w_waddr_nxt;
  logic [SIZE-1:0]       r_wdata,   w_wdata_nxt;
  logic                  r_loading, w_loading_nxt;
  logic                  r_done,    w_done_nxt;
  logic                  r_error,   w_error_nxt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= IDLE;
      r_sr      <= '0;
      r_bcnt    <= '0;
      r_addr    <= '0;
      r_words   <= '0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_loading <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sr      <= w_sr_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_addr    <= w_addr_nxt;
      r_words   <= w_words_nxt;
      r_we      <= w_we_nxt;
      r_waddr   <= w_waddr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_loading <= w_loading_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sr_nxt      = r_sr;
    w_bcnt_nxt    = r_bcnt;
    w_addr_nxt    = r_addr;
    w_words_nxt   = r_words;
    w_we_nxt      = 1'b0;
    w_waddr_nxt   = r_waddr;
    w_wdata_nxt   = r_wdata;
    w_loading_nxt = r_loading;
    w_done_nxt    = 1'b0;
    w_error_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_rx_valid && bus.i_rx_data == CMD_LOAD) begin
          w_state_nxt   = COUNT;
          w_loading_nxt = 1'b1;
        end
      end
      COUNT: begin
        if (bus.i_rx_valid) begin
          if (bus.i_rx_data == 8'h00 || int'(bus.i_rx_data) > MAX_INSTRUCTION) begin
            w_error_nxt   = 1'b1;
            w_loading_nxt = 1'b0;
            w_state_nxt   = IDLE;
          end else begin
            w_words_nxt = (ADDR_WIDTH+1)'(bus.i_rx_data);
            w_addr_nxt  = '0;
            w_bcnt_nxt  = '0;
            w_state_nxt = BYTES;
          end
        end
      end
      BYTES: begin
        if (bus.i_rx_valid) begin
          w_sr_nxt   = {r_sr[SIZE-17:0], bus.i_rx_data};
          w_bcnt_nxt = r_bcnt + 2'd1;
          if (r_bcnt == 2'd3) begin
            w_wdata_nxt = {r_sr, bus.i_rx_data};
            w_waddr_nxt = r_addr;
            w_we_nxt    = 1'b1;
            w_addr_nxt  = r_addr + ADDR_ONE;
            w_words_nxt = r_words - WORD_ONE;
            // Loading stays high through the final strobe; DONE drops it a cycle later.
            if (r_words == WORD_ONE) w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        w_done_nxt    = 1'b1;
        w_loading_nxt = 1'b0;
        w_state_nxt   = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.o_inst_write_enable = r_we;
  assign bus.o_write_addr        = r_waddr;
  assign bus.o_write_data        = r_wdata;
  assign bus.o_loading           = r_loading;
  assign bus.o_done              = r_done;
  assign bus.o_error             = r_error;
endmodule
